trackball_counter: RTL

Parametrised trackball/spinner position counter bank that replaces the fixed two-axis LETA interface. It synchronises CHANNELS pairs of raw optical inputs and decodes each pair as direction/clock or 4x quadrature. It keeps a wrapping up/down counter per channel, and gives the CPU registered read, preload write and per-channel "moved" status. It sits on the CPU bus in the 0x9400 input window, alongside the player-switch port.

---
 rtl/trackball_counter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/trackball_counter.sv
// trackball_counter: synchronises CHANNELS raw trackball/spinner input pairs, decodes dir/clock or 4x quadrature, keeps wrapping up/down counters with CPU read/preload/status.
// Latency: pin captured on ce edge k -> count event registered at ce edge k+2 -> counter at the next clk edge; dout 1 clk after the rd_n-low cycle.
// No backpressure: every event and bus access is absorbed in its cycle; a write overrides a same-cycle event. Optional glitch filter: `define TRACKBALL_FILTER_EN.
module trackball_counter #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int ADDR_W   = 3,
    parameter int QUAD     = 0,
    parameter int FILT_CYC = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ce,
    input  logic [CHANNELS-1:0] tb_a,
    input  logic [CHANNELS-1:0] tb_b,
    input  logic [CHANNELS-1:0] flip,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic [CNT_W-1:0]    din,
    output logic [CNT_W-1:0]    dout,
    output logic [CHANNELS-1:0] moved,
    output logic                err
);

`ifdef TRACKBALL_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif
    // Number of ce samples after reset before the history holds real (and settled) input data;
    // events are suppressed until then so an input already high at release never counts.
    localparam int PRIME   = FILT_EN ? 3 + FILT_CYC : 3;
    localparam int PRIME_W = $clog2(PRIME + 1);

    logic [CHANNELS-1:0] sync1_a, sync1_b, sync2_a, sync2_b;
    logic [CHANNELS-1:0] cur_a, cur_b, prev_a, prev_b;
    logic [PRIME_W-1:0]  prime_cnt;
    logic                prime_done;
    logic [CHANNELS-1:0] det_ev, det_up, det_ill;
    logic [CHANNELS-1:0] ev_q, up_q;
    logic                ill_q, err_q;
    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [CNT_W-1:0]    status, rd_val;
    logic                rd, wr;

    assign prime_done = (prime_cnt == PRIME_W'(PRIME));
    assign rd = ~rd_n;
    assign wr = ~wr_n;

    // Two-flop synchroniser, decoder history and post-reset priming, all advanced on ce
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_a   <= '0;
            sync1_b   <= '0;
            sync2_a   <= '0;
            sync2_b   <= '0;
            prev_a    <= '0;
            prev_b    <= '0;
            prime_cnt <= '0;
        end else if (ce) begin
            sync1_a <= tb_a;
            sync1_b <= tb_b;
            sync2_a <= sync1_a;
            sync2_b <= sync1_b;
            prev_a  <= cur_a;
            prev_b  <= cur_b;
            if (!prime_done) prime_cnt <= prime_cnt + 1'b1;
        end
    end

`ifdef TRACKBALL_FILTER_EN
    localparam int FC_W = $clog2(FILT_CYC + 1);
    logic [FC_W-1:0]     fcnt_a [CHANNELS];
    logic [FC_W-1:0]     fcnt_b [CHANNELS];
    logic [CHANNELS-1:0] filt_a, filt_b;

    // Per-bit stability filter: follow the input only after FILT_CYC consecutive differing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_a <= '0;
            filt_b <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                fcnt_a[i] <= '0;
                fcnt_b[i] <= '0;
            end
        end else if (ce) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sync2_a[i] == filt_a[i]) begin
                    fcnt_a[i] <= '0;
                end else if (fcnt_a[i] == FC_W'(FILT_CYC - 1)) begin
                    filt_a[i] <= sync2_a[i];
                    fcnt_a[i] <= '0;
                end else begin
                    fcnt_a[i] <= fcnt_a[i] + 1'b1;
                end
                if (sync2_b[i] == filt_b[i]) begin
                    fcnt_b[i] <= '0;
                end else if (fcnt_b[i] == FC_W'(FILT_CYC - 1)) begin
                    filt_b[i] <= sync2_b[i];
                    fcnt_b[i] <= '0;
                end else begin
                    fcnt_b[i] <= fcnt_b[i] + 1'b1;
                end
            end
        end
    end

    assign cur_a = filt_a;
    assign cur_b = filt_b;
`else
    assign cur_a = sync2_a;
    assign cur_b = sync2_b;
`endif

    // Decode current vs previous sample into count event, direction and illegal jump
    always_comb begin
        det_ev  = '0;
        det_up  = '0;
        det_ill = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (QUAD == 0) begin
                det_ev[i] = cur_b[i] & ~prev_b[i];
                det_up[i] = cur_a[i] ^ flip[i];
            end else begin
                case ({prev_a[i], prev_b[i], cur_a[i], cur_b[i]})
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                        det_ev[i] = 1'b1;
                        det_up[i] = ~flip[i];
                    end
                    4'b0100, 4'b1101, 4'b1011, 4'b0010: begin
                        det_ev[i] = 1'b1;
                        det_up[i] = flip[i];
                    end
                    4'b0011, 4'b1100, 4'b0110, 4'b1001: det_ill[i] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Register decoded events; they last exactly one clk even if ce then drops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ev_q  <= '0;
            up_q  <= '0;
            ill_q <= 1'b0;
        end else begin
            ev_q  <= (ce && prime_done) ? det_ev : '0;
            up_q  <= det_up;
            ill_q <= ce && prime_done && (|det_ill);
        end
    end

    // Register-map read mux over pre-update state
    always_comb begin
        status = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i < CNT_W - 1) status[i] = moved[i];
        end
        status[CNT_W-1] = err;
        rd_val = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (addr == ADDR_W'(i)) rd_val = cnt[i];
        end
        if (addr == ADDR_W'(CHANNELS)) rd_val = status;
    end

    // Counters, moved flags, err and read data; a write beats a same-cycle count event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
            moved <= '0;
            err_q <= 1'b0;
            dout  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr && addr == ADDR_W'(i)) begin
                    cnt[i] <= din;
                end else if (ev_q[i]) begin
                    cnt[i] <= up_q[i] ? cnt[i] + 1'b1 : cnt[i] - 1'b1;
                end
                if (ev_q[i] && !(wr && addr == ADDR_W'(i))) begin
                    moved[i] <= 1'b1;
                end else if (rd && addr == ADDR_W'(i)) begin
                    moved[i] <= 1'b0;
                end
            end
            if (ill_q) begin
                err_q <= 1'b1;
            end else if (rd && addr == ADDR_W'(CHANNELS)) begin
                err_q <= 1'b0;
            end
            if (rd) dout <= rd_val;
        end
    end

    assign err = (QUAD != 0) ? err_q : 1'b0;

endmodule
